// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU constants and the writeback request record used by the ALU and MDU
// writeback ports.
package regfile_scoreboard_pkg;

    localparam int NUM_REGS   = 32;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 8;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard_wb_port_arbiter.sv
// Single register-file write port: ALU-first priority grant, MDU starvation
// counter and the registered rf_* write signals.
module wb_port_arbiter
    import regfile_scoreboard_pkg::*;
#(
    parameter int STARVE_MAX = regfile_scoreboard_pkg::STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  wb_req_t           alu,
    input  wb_req_t           mdu,
    output logic              mdu_ready,
    output logic              throttle,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    wb_req_t          grant;
    logic             grant_write;

    // With no ALU request the MDU record passes through; its valid bit then
    // decides whether anything is granted at all.
    always_comb begin
        grant = alu.valid ? alu : mdu;
    end

    assign grant_write = grant.valid && (grant.rd != REG_ZERO);
    assign mdu_ready   = mdu.valid && !alu.valid;
    assign throttle    = (starve_cnt == STARVE_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!mdu.valid || mdu_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Grant-to-write stage: a grant to register 0 is consumed without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_write;
            if (grant_write) begin
                rf_waddr <= grant.rd;
                rf_wdata <= grant.data;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file write controller: in-flight write scoreboard, RAW/WAW issue
// stall and the shared write port.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int NUM_REGS   = regfile_scoreboard_pkg::NUM_REGS,
    parameter int ADDR_W     = regfile_scoreboard_pkg::ADDR_W,
    parameter int DATA_W     = regfile_scoreboard_pkg::DATA_W,
    parameter int STARVE_MAX = regfile_scoreboard_pkg::STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rs,
    input  logic [ADDR_W-1:0]   issue_rt,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_rd_we,
    output logic                issue_stall,
    input  logic                alu_wb_valid,
    input  logic [ADDR_W-1:0]   alu_wb_rd,
    input  logic [DATA_W-1:0]   alu_wb_data,
    input  logic                mdu_wb_valid,
    input  logic [ADDR_W-1:0]   mdu_wb_rd,
    input  logic [DATA_W-1:0]   mdu_wb_data,
    output logic                mdu_wb_ready,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [NUM_REGS-1:0] pending
);

    wb_req_t             alu_req;
    wb_req_t             mdu_req;
    logic                throttle;
    logic                hazard;
    logic                issue_set;
    logic [NUM_REGS-1:0] pending_next;

    assign alu_req = '{valid: alu_wb_valid, rd: alu_wb_rd, data: alu_wb_data};
    assign mdu_req = '{valid: mdu_wb_valid, rd: mdu_wb_rd, data: mdu_wb_data};

    wb_port_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu       (alu_req),
        .mdu       (mdu_req),
        .mdu_ready (mdu_wb_ready),
        .throttle  (throttle),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    // Stall looks only at registered pending, so a cleared bit becomes visible
    // the cycle after the register file has captured the data.
    assign hazard = pending[issue_rs] || pending[issue_rt] ||
                    (issue_rd_we && pending[issue_rd]);
    assign issue_stall = issue_valid && (hazard || throttle);
    assign issue_set   = issue_valid && !issue_stall && issue_rd_we &&
                         (issue_rd != REG_ZERO);

    // Set is applied after clear so a same-index collision leaves the bit set.
    always_comb begin
        pending_next = pending;
        if (rf_we) begin
            pending_next[rf_waddr] = 1'b0;
        end
        if (issue_set) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: cycle table plus hand-written
// reset, starvation and WAW sequences.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic        issue_stall;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        mdu_wb_valid;
    logic [4:0]  mdu_wb_rd;
    logic [31:0] mdu_wb_data;
    logic        mdu_wb_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    int total;
    int bad;
    int collide_bad;

    typedef struct {
        logic        iv;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        we;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        e_stall;
        logic        e_ready;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vecs[11];

    regfile_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_rd     (issue_rd),
        .issue_rd_we  (issue_rd_we),
        .issue_stall  (issue_stall),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_rd    (alu_wb_rd),
        .alu_wb_data  (alu_wb_data),
        .mdu_wb_valid (mdu_wb_valid),
        .mdu_wb_rd    (mdu_wb_rd),
        .mdu_wb_data  (mdu_wb_data),
        .mdu_wb_ready (mdu_wb_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Same-index set and clear on one edge must never happen.
    always @(posedge clk) begin
        if (rst_n && rf_we && issue_valid && !issue_stall && issue_rd_we &&
            issue_rd != 5'd0 && issue_rd == rf_waddr) begin
            collide_bad++;
            $display("FAIL set_clear_collision: reg %0d set and cleared on one edge", issue_rd);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        issue_rs     = 5'd0;
        issue_rt     = 5'd0;
        issue_rd     = 5'd0;
        issue_rd_we  = 1'b0;
        alu_wb_valid = 1'b0;
        alu_wb_rd    = 5'd0;
        alu_wb_data  = 32'd0;
        mdu_wb_valid = 1'b0;
        mdu_wb_rd    = 5'd0;
        mdu_wb_data  = 32'd0;
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic we);
        issue_valid = v;
        issue_rs    = rs;
        issue_rt    = rt;
        issue_rd    = rd;
        issue_rd_we = we;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        collide_bad = 0;

        //   iv rs rt rd we  av ard adata          mv mrd mdata         stl rdy we wa  wdata          pend
        vecs[0]  = '{1, 1, 2, 3, 1,  0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h8};
        vecs[1]  = '{1, 3, 0, 4, 1,  0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0, 32'h0,         32'h8};
        vecs[2]  = '{1, 3, 0, 4, 1,  1, 3, 32'hDEADBEEF,  0, 0, 32'h0,         1, 0, 1, 3, 32'hDEADBEEF,  32'h8};
        vecs[3]  = '{1, 3, 0, 4, 1,  0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 3, 32'hDEADBEEF,  32'h0};
        vecs[4]  = '{1, 3, 0, 4, 1,  0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 3, 32'hDEADBEEF,  32'h10};
        vecs[5]  = '{1, 0, 0, 0, 1,  0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 3, 32'hDEADBEEF,  32'h10};
        vecs[6]  = '{1, 0, 0, 0, 0,  1, 0, 32'h55,        0, 0, 32'h0,         0, 0, 0, 3, 32'hDEADBEEF,  32'h10};
        vecs[7]  = '{0, 0, 0, 0, 0,  1, 5, 32'hA5A5A5A5,  1, 6, 32'h12345678,  0, 0, 1, 5, 32'hA5A5A5A5,  32'h10};
        vecs[8]  = '{0, 0, 0, 0, 0,  0, 0, 32'h0,         1, 6, 32'h12345678,  0, 1, 1, 6, 32'h12345678,  32'h10};
        vecs[9]  = '{0, 0, 0, 0, 0,  1, 4, 32'h1,         0, 0, 32'h0,         0, 0, 1, 4, 32'h1,         32'h10};
        vecs[10] = '{0, 0, 0, 0, 0,  0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 4, 32'h1,         32'h0};

        idle();
        rst_n = 1'b0;
        #12;
        chk("reset_pending", pending, 32'h0);
        chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        chk("reset_stall", {31'd0, issue_stall}, 32'd0);
        chk("reset_mdu_ready", {31'd0, mdu_wb_ready}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // RAW stall, register 0 handling and ALU/MDU conflict
        for (int i = 0; i < 11; i++) begin
            set_issue(vecs[i].iv, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].we);
            alu_wb_valid = vecs[i].av;
            alu_wb_rd    = vecs[i].ard;
            alu_wb_data  = vecs[i].adata;
            mdu_wb_valid = vecs[i].mv;
            mdu_wb_rd    = vecs[i].mrd;
            mdu_wb_data  = vecs[i].mdata;
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, issue_stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d_mdu_ready", i), {31'd0, mdu_wb_ready}, {31'd0, vecs[i].e_ready});
            cyc();
            chk($sformatf("v%0d_rf_we", i), {31'd0, rf_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_rf_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].e_waddr});
            chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_pending", i), pending, vecs[i].e_pend);
        end
        idle();

        // Starvation: ALU busy for 12 cycles while MDU waits
        mdu_wb_valid = 1'b1;
        mdu_wb_rd    = 5'd8;
        mdu_wb_data  = 32'hCAFE0008;
        set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            alu_wb_valid = 1'b1;
            alu_wb_rd    = 5'd10;
            alu_wb_data  = k;
            #1;
            chk($sformatf("starve%0d_stall", k), {31'd0, issue_stall}, (k >= 8) ? 32'd1 : 32'd0);
            chk($sformatf("starve%0d_mdu_ready", k), {31'd0, mdu_wb_ready}, 32'd0);
            cyc();
            chk($sformatf("starve%0d_rf_waddr", k), {27'd0, rf_waddr}, 32'd10);
        end
        alu_wb_valid = 1'b0;
        #1;
        chk("starve_grant_ready", {31'd0, mdu_wb_ready}, 32'd1);
        chk("starve_grant_stall", {31'd0, issue_stall}, 32'd1);
        cyc();
        chk("starve_mdu_we", {31'd0, rf_we}, 32'd1);
        chk("starve_mdu_waddr", {27'd0, rf_waddr}, 32'd8);
        chk("starve_mdu_wdata", rf_wdata, 32'hCAFE0008);
        mdu_wb_valid = 1'b0;
        #1;
        chk("starve_cleared_stall", {31'd0, issue_stall}, 32'd0);
        cyc();
        idle();

        // WAW: rd=7 pending from an MDU op, second writer of r7 waits for commit
        set_issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
        #1;
        chk("waw_first_stall", {31'd0, issue_stall}, 32'd0);
        cyc();
        chk("waw_pending_set", pending, 32'h80);
        #1;
        chk("waw_second_stall", {31'd0, issue_stall}, 32'd1);
        cyc();
        mdu_wb_valid = 1'b1;
        mdu_wb_rd    = 5'd7;
        mdu_wb_data  = 32'd77;
        #1;
        chk("waw_mdu_ready", {31'd0, mdu_wb_ready}, 32'd1);
        chk("waw_stall_at_grant", {31'd0, issue_stall}, 32'd1);
        cyc();
        chk("waw_commit_we", {31'd0, rf_we}, 32'd1);
        chk("waw_commit_waddr", {27'd0, rf_waddr}, 32'd7);
        chk("waw_pending_held", pending, 32'h80);
        mdu_wb_valid = 1'b0;
        #1;
        chk("waw_stall_at_commit", {31'd0, issue_stall}, 32'd1);
        cyc();
        chk("waw_pending_cleared", pending, 32'h0);
        #1;
        chk("waw_accept_stall", {31'd0, issue_stall}, 32'd0);
        cyc();
        chk("waw_pending_reset", pending, 32'h80);
        idle();

        // Reset mid-stream with pending=0x4 and a write in flight
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd7;
        alu_wb_data  = 32'd1;
        cyc();
        idle();
        cyc();
        chk("pre_rst_pending_clear", pending, 32'h0);
        set_issue(1'b1, 5'd0, 5'd0, 5'd2, 1'b1);
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 5'd9;
        alu_wb_data  = 32'd99;
        cyc();
        idle();
        chk("pre_rst_pending", pending, 32'h4);
        chk("pre_rst_rf_we", {31'd0, rf_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pending", pending, 32'h0);
        chk("async_rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("async_rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        #2;
        rst_n = 1'b1;
        set_issue(1'b1, 5'd2, 5'd0, 5'd0, 1'b0);
        #1;
        chk("post_rst_stall", {31'd0, issue_stall}, 32'd0);
        cyc();
        chk("post_rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("post_rst_pending", pending, 32'h0);
        idle();
        cyc();

        bad += collide_bad;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
